mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath (PC, IR, GRF, ALU, EXT, DM).
- Sequences each instruction through fetch/decode/execute/memory/write-back.
- Drives all datapath enables and muxes, including the immediate-extender mode select (ext_op).
- Handshakes with a single shared memory port that may insert wait states.

Parameters:
- TIMEOUT, 255, max cycles to wait for mem_ready before raising mem_err (8-bit counter; TIMEOUT must be ≤255).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low (reset==0 at posedge resets)
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU A==B flag
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  memory write (valid with mem_req)
- mem_src  out  1  address select: 0=PC (fetch), 1=ALU result (data)
- pc_we  out  1  PC write enable
- npc_sel  out  2  0=PC+4, 1=branch target, 2=j/jal target, 3=GRF[rs] (jr)
- ir_we  out  1  IR write enable
- ext_op  out  1  0=sign-extend, 1=zero-extend
- alu_src  out  1  0=GRF[rt], 1=EXT output
- alu_op  out  3  0=ADD, 1=SUB, 2=OR, 3=LUI (B<<16)
- reg_we  out  1  GRF write enable
- reg_dst  out  2  0=rt, 1=rd, 2=$31
- wd_sel  out  2  0=ALU, 1=mem read data, 2=PC (already PC+4)
- state  out  3  current state (debug)
- illegal  out  1  one-cycle pulse on an unrecognised instruction
- mem_err  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=7.
- Reset (reset==0 at posedge): state=IF, timeout counter=0, mem_err=0, illegal=0. Reset overrides everything, including a pending memory request.
- All control outputs are combinational from state+opcode/funct. Outside the states listed below they are 0 (ext_op=0, alu_op=ADD, npc_sel=0).
- Supported instructions: addu, subu (op 0, funct 0x21/0x23), jr (op 0, funct 0x08), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03. nop = sll 0 and is treated as a legal no-op (funct 0x00).
- ext_op=1 for ori and lui; 0 for every other instruction.
- IF:
  - mem_req=1, mem_src=0.
  - Held until mem_ready=1. In that same cycle: ir_we=1, pc_we=1, npc_sel=0; next state ID.
- ID:
  - j: pc_we=1, npc_sel=2 → IF.
  - jal: as j, plus reg_we=1, reg_dst=2, wd_sel=2 → IF.
  - jr: pc_we=1, npc_sel=3 → IF.
  - nop → IF.
  - Illegal: illegal=1 → IF (PC has already advanced, so the instruction is skipped).
  - All others → EX.
- EX:
  - R-type: alu_src=0, alu_op=ADD/SUB → WB.
  - ori: alu_src=1, alu_op=OR → WB.
  - lui: alu_src=1, alu_op=LUI → WB.
  - lw/sw: alu_src=1, alu_op=ADD → MEM.
  - beq: alu_src=0, alu_op=SUB; if zero=1 then pc_we=1, npc_sel=1 → IF.
- MEM:
  - mem_req=1, mem_src=1, mem_we=(sw); held until mem_ready.
  - On mem_ready: sw → IF, lw → WB.
- WB:
  - reg_we=1. reg_dst: R-type=1, otherwise 0. wd_sel: lw=1, otherwise 0 → IF.
- Wait counter:
  - Clears on entry to IF or MEM and increments each cycle mem_req=1 && mem_ready=0.
  - When the count reaches TIMEOUT with mem_ready still 0: mem_err=1, state → ERR.
  - ERR is absorbing: all outputs 0 until reset.
- mem_ready asserted while mem_req=0: ignored.
- Latencies with zero wait states: R/ori/lui/lw = 4 or 5 cycles (lw=5), sw=4, beq=3, j/jal/jr=2.

Decomposition:
- Shared package `mips_defs`: opcode/funct constants, state encoding, alu_op / npc_sel / reg_dst / wd_sel encodings, and ext_op values (EXT_SIGN=0, EXT_ZERO=1) matching the extender.
- One sub-module, `mc_decode`: combinational decode of opcode/funct into instruction-class one-hots (is_rtype, is_ori, …, is_illegal).
- The FSM, wait counter and output logic stay in `mc_ctrl`.

Test Plan:
- Reset held low 3 cycles, mem_ready=1 → state=0, mem_req=1, mem_src=0, mem_err=0. After the reset release, the fetch completes on the first edge.
- ori (op 0x0D), mem_ready=1 always → state sequence 0,1,2,4,0. In EX: ext_op=1, alu_src=1, alu_op=2. In WB: reg_we=1, reg_dst=0.
- lw (0x23) with mem_ready low for 3 MEM cycles → MEM lasts 4 cycles with mem_we=0, mem_src=1, ext_op=0. WB: wd_sel=1. Total 8 cycles.
- beq (0x04): first with zero=1, then with zero=0 → zero=1 case: EX asserts pc_we=1, npc_sel=1. zero=0 case: pc_we=0. Both return to IF after 3 cycles.
- jal (0x03) → ID asserts pc_we=1, npc_sel=2, reg_we=1, reg_dst=2, wd_sel=2. Next state IF. Opcode 0x3F → illegal=1 for exactly one cycle, then IF.
- mem_ready held 0 in IF with TIMEOUT=4 → mem_err=1 and state=7 after 4 stall cycles. Both stay set until reset=0, which returns state=0 and mem_err=0.

Source files
------------

// File: rtl/mips_defs.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// FSM states, datapath mux selects and the decoded instruction class.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Extender mode, matching the EXT block
  localparam logic EXT_SIGN = 1'b0;
  localparam logic EXT_ZERO = 1'b1;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4,
    ST_ERR = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_OR  = 3'd2,
    ALU_LUI = 3'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    NPC_PC4 = 2'd0,
    NPC_BR  = 2'd1,
    NPC_JMP = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_RA = 2'd2
  } reg_dst_e;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_MEM = 2'd1,
    WD_PC  = 2'd2
  } wd_sel_e;

  // One-hot instruction class
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic nop;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic illegal;
  } dec_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Shared memory port handshake between the controller and memory.
interface mc_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_src;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_src, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_src, output mem_ready);
endinterface

// File: rtl/mc_decode.sv
// Combinational decode of IR opcode/funct into one-hot instruction classes.
module mc_decode
  import mips_defs::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  // Exactly one class bit is set for any opcode/funct pair
  always_comb begin
    dec_o = '0;
    case (opcode_i)
      OP_RTYPE:
        case (funct_i)
          FN_ADDU: dec_o.addu    = 1'b1;
          FN_SUBU: dec_o.subu    = 1'b1;
          FN_JR:   dec_o.jr      = 1'b1;
          FN_SLL:  dec_o.nop     = 1'b1;
          default: dec_o.illegal = 1'b1;
        endcase
      OP_ORI:  dec_o.ori     = 1'b1;
      OP_LUI:  dec_o.lui     = 1'b1;
      OP_LW:   dec_o.lw      = 1'b1;
      OP_SW:   dec_o.sw      = 1'b1;
      OP_BEQ:  dec_o.beq     = 1'b1;
      OP_J:    dec_o.j       = 1'b1;
      OP_JAL:  dec_o.jal     = 1'b1;
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB, drives datapath
// enables and selects, and guards the shared memory port with a wait timeout.
module mc_ctrl
  import mips_defs::*;
#(
  parameter int unsigned TIMEOUT = 255
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  mc_ctrl_if.master  mem,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic       ir_we,
  output logic       ext_op,
  output logic       alu_src,
  output logic [2:0] alu_op,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic [2:0] state,
  output logic       illegal,
  output logic       mem_err
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;
  dec_t       dec;
  logic       ext_sel;

  mc_decode u_decode (
    .opcode_i (opcode),
    .funct_i  (funct),
    .dec_o    (dec)
  );

  assign ext_sel = (dec.ori || dec.lui) ? EXT_ZERO : EXT_SIGN;
  assign state   = state_q;
  assign mem_err = err_q;

  // State, wait counter and sticky error registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IF;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Next-state, wait-counter update and control outputs
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    err_d       = err_q;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.mem_src = 1'b0;
    pc_we       = 1'b0;
    npc_sel     = NPC_PC4;
    ir_we       = 1'b0;
    ext_op      = EXT_SIGN;
    alu_src     = 1'b0;
    alu_op      = ALU_ADD;
    reg_we      = 1'b0;
    reg_dst     = DST_RT;
    wd_sel      = WD_ALU;
    illegal     = 1'b0;

    case (state_q)
      ST_IF: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_ID;
        end
      end
      ST_ID: begin
        ext_op  = ext_sel;
        state_d = ST_EX;
        if (dec.j || dec.jal) begin
          pc_we   = 1'b1;
          npc_sel = NPC_JMP;
          state_d = ST_IF;
        end
        if (dec.jal) begin
          reg_we  = 1'b1;
          reg_dst = DST_RA;
          wd_sel  = WD_PC;
        end
        if (dec.jr) begin
          pc_we   = 1'b1;
          npc_sel = NPC_JR;
          state_d = ST_IF;
        end
        if (dec.nop) state_d = ST_IF;
        if (dec.illegal) begin
          illegal = 1'b1;
          state_d = ST_IF;
        end
      end
      ST_EX: begin
        ext_op  = ext_sel;
        state_d = ST_WB;
        if (dec.subu) begin
          alu_op = ALU_SUB;
        end else if (dec.ori) begin
          alu_src = 1'b1;
          alu_op  = ALU_OR;
        end else if (dec.lui) begin
          alu_src = 1'b1;
          alu_op  = ALU_LUI;
        end else if (dec.lw || dec.sw) begin
          alu_src = 1'b1;
          state_d = ST_MEM;
        end else if (dec.beq) begin
          alu_op  = ALU_SUB;
          state_d = ST_IF;
          if (zero) begin
            pc_we   = 1'b1;
            npc_sel = NPC_BR;
          end
        end else if (!dec.addu) begin
          state_d = ST_IF;
        end
      end
      ST_MEM: begin
        ext_op      = ext_sel;
        mem.mem_req = 1'b1;
        mem.mem_src = 1'b1;
        mem.mem_we  = dec.sw;
        if (mem.mem_ready) state_d = dec.lw ? ST_WB : ST_IF;
      end
      ST_WB: begin
        ext_op  = ext_sel;
        reg_we  = 1'b1;
        reg_dst = (dec.addu || dec.subu) ? DST_RD : DST_RT;
        wd_sel  = dec.lw ? WD_MEM : WD_ALU;
        state_d = ST_IF;
      end
      ST_ERR: ;
      default: state_d = ST_IF;
    endcase

    // Stall accounting shared by IF and MEM; the cycle that would bring the
    // count to TIMEOUT diverts to ERR instead.
    if (mem.mem_req && !mem.mem_ready) begin
      if (wait_q == WAIT_LAST) begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
    if (state_d != state_q && (state_d == ST_IF || state_d == ST_MEM)) wait_d = '0;
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: builds the expected per-cycle control trace
// of each instruction from its class and wait states, then replays it.
module tb_mc_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, src, pcwe;
    logic [1:0] npc;
    logic       irwe, ext, asrc;
    logic [2:0] aop;
    logic       rwe;
    logic [1:0] rdst, wds;
    logic       ill, err;
  } exp_t;

  typedef struct {
    exp_t e;
    logic rdy;
  } step_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       pc_we, ir_we, ext_op, alu_src, reg_we, illegal, mem_err;
  logic [1:0] npc_sel, reg_dst, wd_sel;
  logic [2:0] alu_op, state;

  mc_ctrl_if mem_if ();

  mc_ctrl #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .opcode  (opcode),
    .funct   (funct),
    .zero    (zero),
    .mem     (mem_if.master),
    .pc_we   (pc_we),
    .npc_sel (npc_sel),
    .ir_we   (ir_we),
    .ext_op  (ext_op),
    .alu_src (alu_src),
    .alu_op  (alu_op),
    .reg_we  (reg_we),
    .reg_dst (reg_dst),
    .wd_sel  (wd_sel),
    .state   (state),
    .illegal (illegal),
    .mem_err (mem_err)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  step_t       trace[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t observed();
    return {state, mem_if.mem_req, mem_if.mem_we, mem_if.mem_src, pc_we, npc_sel,
            ir_we, ext_op, alu_src, alu_op, reg_we, reg_dst, wd_sel, illegal, mem_err};
  endfunction

  function automatic string classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: case (fn)
               6'h21: return "addu";
               6'h23: return "subu";
               6'h08: return "jr";
               6'h00: return "nop";
               default: return "ill";
             endcase
      6'h0D: return "ori";
      6'h0F: return "lui";
      6'h23: return "lw";
      6'h2B: return "sw";
      6'h04: return "beq";
      6'h02: return "j";
      6'h03: return "jal";
      default: return "ill";
    endcase
  endfunction

  task automatic add(input exp_t e, input logic rdy);
    step_t s;
    s.e = e;
    s.rdy = rdy;
    trace.push_back(s);
  endtask

  function automatic exp_t fetch_rec(input logic rdy);
    exp_t e = '0;
    e.req  = 1'b1;
    e.irwe = rdy;
    e.pcwe = rdy;
    return e;
  endfunction

  // Expected cycle-by-cycle trace of one instruction; mem_ready is random
  // outside IF/MEM, where it must have no effect.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int unsigned if_st, input int unsigned mem_st);
    string cls = classify(op, fn);
    logic  ext = (cls == "ori" || cls == "lui");
    exp_t  e;
    for (int unsigned i = 0; i < if_st; i++) add(fetch_rec(1'b0), 1'b0);
    add(fetch_rec(1'b1), 1'b1);
    e = '0; e.st = 3'd1; e.ext = ext;
    case (cls)
      "j":   begin e.pcwe = 1; e.npc = 2; end
      "jal": begin e.pcwe = 1; e.npc = 2; e.rwe = 1; e.rdst = 2; e.wds = 2; end
      "jr":  begin e.pcwe = 1; e.npc = 3; end
      "ill": e.ill = 1;
      default: ;
    endcase
    add(e, 1'($urandom_range(0, 1)));
    if (cls == "j" || cls == "jal" || cls == "jr" || cls == "nop" || cls == "ill") return;
    e = '0; e.st = 3'd2; e.ext = ext;
    case (cls)
      "subu": e.aop = 1;
      "ori":  begin e.asrc = 1; e.aop = 2; end
      "lui":  begin e.asrc = 1; e.aop = 3; end
      "lw", "sw": e.asrc = 1;
      "beq":  begin e.aop = 1; if (z) begin e.pcwe = 1; e.npc = 1; end end
      default: ;
    endcase
    add(e, 1'($urandom_range(0, 1)));
    if (cls == "beq") return;
    if (cls == "lw" || cls == "sw") begin
      e = '0; e.st = 3'd3; e.ext = ext; e.req = 1; e.src = 1; e.we = (cls == "sw");
      for (int unsigned i = 0; i < mem_st; i++) add(e, 1'b0);
      add(e, 1'b1);
      if (cls == "sw") return;
    end
    e = '0; e.st = 3'd4; e.ext = ext; e.rwe = 1;
    e.rdst = (cls == "addu" || cls == "subu") ? 2'd1 : 2'd0;
    e.wds  = (cls == "lw") ? 2'd1 : 2'd0;
    add(e, 1'($urandom_range(0, 1)));
  endtask

  // Replays the queued trace; called right after an active edge.
  task automatic run_trace(input string name);
    step_t s;
    while (trace.size() > 0) begin
      s = trace.pop_front();
      mem_if.mem_ready = s.rdy;
      @(negedge clk);
      check($sformatf("%s st%0d", name, s.e.st), 32'(observed()), 32'(s.e));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int unsigned if_st, input int unsigned mem_st);
    opcode = op;
    funct  = fn;
    zero   = z;
    build(op, fn, z, if_st, mem_st);
    run_trace(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [11] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
    logic [5:0] fns [11] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    logic [5:0] op, fn;
    int unsigned idx;
    exp_t e;

    reset = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_if.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("reset", 32'(observed()), 32'(fetch_rec(1'b1)));
    end
    reset = 1'b1;

    do_instr("ori",       6'h0D, 6'h00, 1'b0, 0, 0);
    do_instr("lw_wait3",  6'h23, 6'h00, 1'b0, 0, 3);
    do_instr("beq_z1",    6'h04, 6'h00, 1'b1, 0, 0);
    do_instr("beq_z0",    6'h04, 6'h00, 1'b0, 0, 0);
    do_instr("jal",       6'h03, 6'h00, 1'b0, 0, 0);
    do_instr("ill_3f",    6'h3F, 6'h00, 1'b0, 0, 0);
    do_instr("sw_wait",   6'h2B, 6'h11, 1'b1, 3, 3);

    for (int n = 0; n < 250; n++) begin
      idx = $urandom_range(0, 12);
      if (idx < 11) begin
        op = ops[idx];
        fn = (op == 6'h00) ? fns[idx] : 6'($urandom);
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      do_instr($sformatf("rnd%0d_%s", n, classify(op, fn)), op, fn, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
    end

    // Reset while a data access is still waiting
    opcode = 6'h23; funct = '0; zero = 1'b0;
    build(6'h23, 6'h00, 1'b0, 0, 3);
    while (trace.size() > 4) void'(trace.pop_back());
    run_trace("lw_abort");
    mem_if.mem_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_in_mem", 32'(observed()), 32'(fetch_rec(1'b0)));
    reset = 1'b1;

    // Fetch timeout: four stalled cycles, then absorbing error state
    opcode = 6'h0D;
    for (int i = 0; i < 4; i++) add(fetch_rec(1'b0), 1'b0);
    e = '0; e.st = 3'd7; e.err = 1'b1;
    for (int i = 0; i < 3; i++) add(e, 1'($urandom_range(0, 1)));
    run_trace("timeout");
    mem_if.mem_ready = 1'b1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_after_err", 32'(observed()), 32'(fetch_rec(1'b1)));
    reset = 1'b1;
    do_instr("recover_addu", 6'h00, 6'h21, 1'b0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
